// File: rtl/proc_seq_pkg.sv
// Shared types and widths for the processor command sequencer.
package proc_seq_pkg;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
    localparam int F_W       = 3;
    // Widest repeat field any sequencer instance may use. Narrower instances
    // zero-extend their repeat count into this field.
    localparam int REP_W_MAX = 16;

    // One host command as it sits in the FIFO.
    typedef struct packed {
        logic                 mode;
        logic [F_W-1:0]       f;
        logic [ADDR_W-1:0]    ra1;
        logic [ADDR_W-1:0]    ra2;
        logic [ADDR_W-1:0]    dst;
        logic [DATA_W-1:0]    data;
        logic [REP_W_MAX-1:0] rep;
    } proc_cmd_t;

    // IDLE: nothing issuing, nothing pending; ISSUE: write enable high this
    // cycle; HOLD: paused with work still pending.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/proc_sequencer_fifo.sv
// Synchronous command FIFO with an occupancy count. The head entry is shown
// combinationally on o_dout so the sequencer can load it on the pop edge.
module seq_cmd_fifo
    import proc_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  proc_cmd_t                  i_din,
    input  logic                       i_pop,
    output proc_cmd_t                  o_dout,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    proc_cmd_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CNT_W-1:0]   r_count;

    logic               w_push;
    logic               w_pop;

    // Requests that would overflow or underflow are dropped here as well, so
    // the FIFO stays consistent even if a caller misbehaves.
    assign w_push = i_push && (r_count != CNT_FULL);
    assign w_pop  = i_pop  && (r_count != '0);

    assign o_dout  = r_mem[r_rdPtr];
    assign o_count = r_count;

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= i_din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/proc_sequencer.sv
// Command sequencer in front of the processor: buffers host commands, issues
// one operation per cycle, replays commands for their repeat count, and only
// raises the register-file write enable on cycles that really issue.
module proc_sequencer
    import proc_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int REP_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_mode,
    input  logic [F_W-1:0]      cmd_f,
    input  logic [ADDR_W-1:0]   cmd_ra1,
    input  logic [ADDR_W-1:0]   cmd_ra2,
    input  logic [ADDR_W-1:0]   cmd_dst,
    input  logic [DATA_W-1:0]   cmd_data,
    input  logic [REP_W-1:0]    cmd_rep,
    input  logic                pause,
    output logic                proc_mode,
    output logic [F_W-1:0]      proc_f,
    output logic [ADDR_W-1:0]   proc_ra1,
    output logic [ADDR_W-1:0]   proc_ra2,
    output logic [ADDR_W-1:0]   proc_dst,
    output logic [DATA_W-1:0]   proc_data,
    output logic                proc_we,
    output logic                busy,
    output logic [15:0]         issued_cnt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(DEPTH);
    localparam logic [REP_W_MAX-1:0] REP_ONE  = REP_W_MAX'(1);

    // Elaboration-time sanity checks on the parameters.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_badDepth
        $error("proc_sequencer: DEPTH must be a power of two >= 2");
    end
    if (REP_W < 1 || REP_W > REP_W_MAX) begin : g_badRep
        $error("proc_sequencer: REP_W out of range");
    end

    proc_cmd_t              w_cmdIn;
    proc_cmd_t              w_head;
    logic [CNT_W-1:0]       w_count;
    logic                   w_push;
    logic                   w_load;
    logic                   w_repeat;
    logic                   w_pending;

    // The repeat counter shares the FIFO's rep field width; upper bits are
    // always zero because the host count is zero-extended on entry.
    logic [REP_W_MAX-1:0]   r_repLeft;
    logic                   r_mode;
    logic [F_W-1:0]         r_f;
    logic [ADDR_W-1:0]      r_ra1;
    logic [ADDR_W-1:0]      r_ra2;
    logic [ADDR_W-1:0]      r_dst;
    logic [DATA_W-1:0]      r_data;
    logic [15:0]            r_issuedCnt;
    seq_state_e             r_state;
    seq_state_e             w_stateNext;

    // No full bypass: a pop in the same cycle does not reopen a full FIFO.
    assign cmd_ready = (w_count < CNT_FULL) && rst_n;
    assign w_push    = cmd_valid && cmd_ready;

    assign w_cmdIn.mode = cmd_mode;
    assign w_cmdIn.f    = cmd_f;
    assign w_cmdIn.ra1  = cmd_ra1;
    assign w_cmdIn.ra2  = cmd_ra2;
    assign w_cmdIn.dst  = cmd_dst;
    assign w_cmdIn.data = cmd_data;
    assign w_cmdIn.rep  = REP_W_MAX'(cmd_rep);

    // Repeats of the current command take priority over fetching a new one.
    assign w_repeat  = !pause && (r_repLeft != '0);
    assign w_load    = !pause && (r_repLeft == '0) && (w_count != '0);
    assign w_pending = (r_repLeft != '0) || (w_count != '0);

    seq_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_cmdIn),
        .i_pop   (w_load),
        .o_dout  (w_head),
        .o_count (w_count)
    );

    // Issue register: captures the FIFO head on a load, otherwise holds so a
    // repeat re-issues exactly the same fields.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode <= 1'b0;
            r_f    <= '0;
            r_ra1  <= '0;
            r_ra2  <= '0;
            r_dst  <= '0;
            r_data <= '0;
        end else if (w_load) begin
            r_mode <= w_head.mode;
            r_f    <= w_head.f;
            r_ra1  <= w_head.ra1;
            r_ra2  <= w_head.ra2;
            r_dst  <= w_head.dst;
            r_data <= w_head.data;
        end
    end

    // Remaining-repeat counter: reloaded from the head, counted down per issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_repLeft <= '0;
        end else if (w_repeat) begin
            r_repLeft <= r_repLeft - REP_ONE;
        end else if (w_load) begin
            r_repLeft <= w_head.rep;
        end
    end

    // Next state: any issue goes to ISSUE; paused work parks in HOLD.
    always_comb begin
        w_stateNext = IDLE;
        if (w_load || w_repeat) begin
            w_stateNext = ISSUE;
        end else if (pause && w_pending) begin
            w_stateNext = HOLD;
        end
    end

    // State register; the write enable is decoded straight from ISSUE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Count every edge that issues an operation; wraps at 2^16.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_issuedCnt <= '0;
        end else if (w_load || w_repeat) begin
            r_issuedCnt <= r_issuedCnt + 16'd1;
        end
    end

    assign proc_we    = (r_state == ISSUE);
    assign busy       = proc_we || w_pending;
    assign issued_cnt = r_issuedCnt;
    assign proc_mode  = r_mode;
    assign proc_f     = r_f;
    assign proc_ra1   = r_ra1;
    assign proc_ra2   = r_ra2;
    assign proc_dst   = r_dst;
    assign proc_data  = r_data;

endmodule

// File: tb/tb_proc_sequencer.sv
// Scoreboard bench for proc_sequencer: every accepted command pushes its
// expected issues (rep+1 entries with the expected running issue count) and
// a negedge monitor pops and compares one entry per write-enable cycle.
module tb_proc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_mode = 1'b0;
    logic [2:0]  cmd_f = 3'd0;
    logic [4:0]  cmd_ra1 = 5'd0;
    logic [4:0]  cmd_ra2 = 5'd0;
    logic [4:0]  cmd_dst = 5'd0;
    logic [31:0] cmd_data = 32'd0;
    logic [3:0]  cmd_rep = 4'd0;
    logic        pause = 1'b0;
    logic        proc_mode;
    logic [2:0]  proc_f;
    logic [4:0]  proc_ra1;
    logic [4:0]  proc_ra2;
    logic [4:0]  proc_dst;
    logic [31:0] proc_data;
    logic        proc_we;
    logic        busy;
    logic [15:0] issued_cnt;

    typedef struct {
        logic        mode;
        logic [2:0]  f;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  dst;
        logic [31:0] data;
        logic [15:0] seq;
    } expOp_t;

    expOp_t      sbQ[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] expSeq = 16'd0;
    bit          monEn = 1'b0;
    int          curRun = 0;
    int          lastRun = 0;

    proc_sequencer #(
        .DEPTH (4),
        .REP_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_f      (cmd_f),
        .cmd_ra1    (cmd_ra1),
        .cmd_ra2    (cmd_ra2),
        .cmd_dst    (cmd_dst),
        .cmd_data   (cmd_data),
        .cmd_rep    (cmd_rep),
        .pause      (pause),
        .proc_mode  (proc_mode),
        .proc_f     (proc_f),
        .proc_ra1   (proc_ra1),
        .proc_ra2   (proc_ra2),
        .proc_dst   (proc_dst),
        .proc_data  (proc_data),
        .proc_we    (proc_we),
        .busy       (busy),
        .issued_cnt (issued_cnt)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Single comparison point: counts the vector and reports any miscompare.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Present one command, wait (bounded) for acceptance, and record its
    // expected issues in the scoreboard just before the accepting edge.
    task automatic applyStimulus(input logic mode, input logic [2:0] f,
                                 input logic [4:0] ra1, input logic [4:0] ra2,
                                 input logic [4:0] dst, input logic [31:0] data,
                                 input logic [3:0] rep);
        int     waitCycles;
        expOp_t e;
        @(negedge clk);
        cmd_mode  = mode;
        cmd_f     = f;
        cmd_ra1   = ra1;
        cmd_ra2   = ra2;
        cmd_dst   = dst;
        cmd_data  = data;
        cmd_rep   = rep;
        cmd_valid = 1'b1;
        waitCycles = 0;
        while (!cmd_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!cmd_ready) begin
            checkOutput("push_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
        end else begin
            for (int k = 0; k <= int'(rep); k++) begin
                expSeq   = expSeq + 16'd1;
                e.mode   = mode;
                e.f      = f;
                e.ra1    = ra1;
                e.ra2    = ra2;
                e.dst    = dst;
                e.data   = data;
                e.seq    = expSeq;
                sbQ.push_back(e);
            end
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
        end
    endtask

    // Bounded wait for the first write-enable cycle.
    task automatic waitWe(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!proc_we && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(proc_we), 32'd1);
    endtask

    // Bounded wait for the sequencer to drain, then one settling cycle.
    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    // Scoreboard monitor: one expected entry per write-enable cycle, and
    // tracking of back-to-back run lengths.
    always @(negedge clk) begin
        expOp_t e;
        if (monEn && rst_n) begin
            if (proc_we) begin
                curRun++;
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_issue", 32'(proc_we), 32'd0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("sb_mode", 32'(proc_mode), 32'(e.mode));
                    checkOutput("sb_f",    32'(proc_f),    32'(e.f));
                    checkOutput("sb_ra1",  32'(proc_ra1),  32'(e.ra1));
                    checkOutput("sb_ra2",  32'(proc_ra2),  32'(e.ra2));
                    checkOutput("sb_dst",  32'(proc_dst),  32'(e.dst));
                    checkOutput("sb_data", proc_data,      e.data);
                    checkOutput("sb_cnt",  32'(issued_cnt), 32'(e.seq));
                end
            end else begin
                if (curRun != 0) begin
                    lastRun = curRun;
                end
                curRun = 0;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        // Reset held for two edges with a command offered.
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_mode  = 1'b1;
        cmd_dst   = 5'd7;
        cmd_data  = 32'h0000_1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", 32'(cmd_ready), 32'd0);
        checkOutput("rst_we",    32'(proc_we), 32'd0);
        checkOutput("rst_cnt",   32'(issued_cnt), 32'd0);
        checkOutput("rst_busy",  32'(busy), 32'd0);
        checkOutput("rst_data",  proc_data, 32'd0);
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        #1;
        checkOutput("ready_after_rst", 32'(cmd_ready), 32'd1);
        monEn = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("nothing_buffered", 32'(busy), 32'd0);
        checkOutput("no_issue_cnt", 32'(issued_cnt), 32'd0);

        // Single store and its latency.
        applyStimulus(1'b1, 3'd0, 5'd0, 5'd0, 5'd5, 32'hDEAD_BEEF, 4'd0);
        @(negedge clk);
        checkOutput("lat_e0_we",   32'(proc_we), 32'd0);
        checkOutput("lat_e0_busy", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("lat_e1_we",   32'(proc_we), 32'd1);
        checkOutput("st_mode",     32'(proc_mode), 32'd1);
        checkOutput("st_dst",      32'(proc_dst), 32'd5);
        checkOutput("st_data",     proc_data, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("lat_e2_we",   32'(proc_we), 32'd0);
        checkOutput("st_cnt",      32'(issued_cnt), 32'd1);
        checkOutput("st_busy",     32'(busy), 32'd0);

        // Repeated ALU command: four back-to-back issues.
        applyStimulus(1'b0, 3'b010, 5'd1, 5'd2, 5'd1, 32'd0, 4'd3);
        waitIdle("rep_idle");
        checkOutput("rep_run", 32'(lastRun), 32'd4);
        checkOutput("rep_cnt", 32'(issued_cnt), 32'd5);

        // Fill the FIFO while paused; a fifth command must wait.
        @(negedge clk);
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 3'd0, 5'd0, 5'd0, 5'(8 + i),
                          32'hA000_0000 + 32'(i), 4'd0);
        end
        @(negedge clk);
        checkOutput("full_ready", 32'(cmd_ready), 32'd0);
        checkOutput("full_busy",  32'(busy), 32'd1);
        fork
            applyStimulus(1'b1, 3'd0, 5'd0, 5'd0, 5'd12, 32'hA000_0004, 4'd0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("full_hold", 32'(cmd_ready), 32'd0);
                    checkOutput("pause_we",  32'(proc_we), 32'd0);
                end
                pause = 1'b0;
            end
        join
        waitIdle("full_idle");
        checkOutput("full_run", 32'(lastRun), 32'd5);
        checkOutput("full_cnt", 32'(issued_cnt), 32'd10);

        // Pause in the middle of a six-issue repeat.
        applyStimulus(1'b0, 3'b001, 5'd3, 5'd4, 5'd3, 32'd0, 4'd5);
        waitWe("pr_first");
        @(negedge clk);
        checkOutput("pr_second", 32'(proc_we), 32'd1);
        pause = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("pr_paused_we",   32'(proc_we), 32'd0);
            checkOutput("pr_paused_busy", 32'(busy), 32'd1);
        end
        pause = 1'b0;
        waitIdle("pr_idle");
        checkOutput("pr_run", 32'(lastRun), 32'd4);
        checkOutput("pr_cnt", 32'(issued_cnt), 32'd16);
        checkOutput("pr_sb_empty", 32'(sbQ.size()), 32'd0);

        // Reset while repeating with two commands buffered.
        applyStimulus(1'b0, 3'b100, 5'd5, 5'd6, 5'd7, 32'd0, 4'd7);
        applyStimulus(1'b1, 3'd0, 5'd0, 5'd0, 5'd9,  32'h0000_0055, 4'd0);
        applyStimulus(1'b1, 3'd0, 5'd0, 5'd0, 5'd10, 32'h0000_0066, 4'd0);
        @(negedge clk);
        checkOutput("mid_we", 32'(proc_we), 32'd1);
        monEn = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sbQ.delete();
        expSeq = 16'd0;
        checkOutput("mr_we",   32'(proc_we), 32'd0);
        checkOutput("mr_mode", 32'(proc_mode), 32'd0);
        checkOutput("mr_f",    32'(proc_f), 32'd0);
        checkOutput("mr_ra1",  32'(proc_ra1), 32'd0);
        checkOutput("mr_ra2",  32'(proc_ra2), 32'd0);
        checkOutput("mr_dst",  32'(proc_dst), 32'd0);
        checkOutput("mr_data", proc_data, 32'd0);
        checkOutput("mr_busy", 32'(busy), 32'd0);
        checkOutput("mr_cnt",  32'(issued_cnt), 32'd0);
        monEn = 1'b1;
        repeat (8) begin
            @(negedge clk);
            checkOutput("mr_quiet_we", 32'(proc_we), 32'd0);
        end

        // Fresh command after reset starts the issue count again.
        applyStimulus(1'b1, 3'd0, 5'd0, 5'd0, 5'd3, 32'h0000_CAFE, 4'd0);
        waitIdle("post_idle");
        checkOutput("post_cnt", 32'(issued_cnt), 32'd1);
        checkOutput("post_sb_empty", 32'(sbQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/proc_sequencer.md
# proc_sequencer

Command sequencer in front of `processor`. It buffers store and ALU commands from a host in a small FIFO and issues them one per cycle onto the processor's control ports. It supports a per-command repeat count for accumulate-style loops, plus a pause control. It also gates the register-file write enable, so the processor writes only when an operation is actually issued.

## Interface
- `DEPTH`, default 4: command FIFO entries; a power of two, at least 2.
- `REP_W`, default 4: width of the repeat field.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `cmd_valid`  in  1: host presents a command.
- `cmd_ready`  out  1: FIFO can accept a command.
- `cmd_mode`  in  1: 1 = store `cmd_data` to `cmd_dst`; 0 = ALU op written to `cmd_dst`.
- `cmd_f`  in  3: ALU function code.
- `cmd_ra1`, `cmd_ra2`  in  5 each: register-file read addresses.
- `cmd_dst`  in  5: destination or store address.
- `cmd_data`  in  32: store data.
- `cmd_rep`  in  `REP_W`: number of extra issues of this command (total issues = rep+1).
- `pause`  in  1: hold issue; the FIFO still accepts commands.
- `proc_mode`  out  1: to `mode`.
- `proc_f`  out  3: to `F`.
- `proc_ra1`, `proc_ra2`  out  5 each: to `read_addr1` and `read_addr2`.
- `proc_dst`  out  5: drives both `dest_addr` and `store_addr`.
- `proc_data`  out  32: to `store_data`.
- `proc_we`  out  1: register-file write enable; replaces the constant 1 inside `processor`.
- `busy`  out  1: FIFO non-empty, or repeats pending, or `proc_we` high.
- `issued_cnt`  out  16: count of issued operations; wraps modulo 2^16.

## Operation
**Push**
- A command is pushed on an edge where `cmd_valid && cmd_ready`.
- `cmd_ready = (count < DEPTH) && rst_n`. There is no full bypass: when full, `cmd_ready` stays 0 even if a pop happens in the same cycle.

**Issue register and repeat counter**
- Issue register: holds `mode`/`f`/`ra1`/`ra2`/`dst`/`data`, which drive the `proc_*` outputs directly.
- `rep_left`: `REP_W`-bit counter of remaining repeats.

**Action on each edge, when not in reset**
- **pause=1:** `proc_we` <= 0; issue register, `rep_left` and FIFO pop side are held.
- **Repeat** (`rep_left != 0` and pause=0): `rep_left` <= `rep_left`−1; `proc_we` <= 1; issue register is unchanged.
- **Load** (`rep_left == 0`, `count != 0`, pause=0):
  - pop the FIFO head into the issue register;
  - `rep_left` <= head.rep;
  - `proc_we` <= 1.
- **Otherwise:** `proc_we` <= 0; the issue register keeps its last value.
- A push and a pop may happen on the same edge: `count` is unchanged and ordering is preserved.

**FSM**
- States: IDLE (`proc_we`=0, nothing pending), ISSUE (`proc_we`=1), HOLD (pause=1 with work pending).
- IDLE→ISSUE on a load.
- ISSUE→ISSUE on a load or repeat.
- ISSUE→HOLD when pause=1 and work is pending.
- ISSUE→IDLE when nothing is pending.
- HOLD→ISSUE when pause drops.

**Counter:** `issued_cnt` increments on every edge where `proc_we` is loaded with 1.

**Reset:** all state clears, including FIFO count, pointers and `rep_left`. Commands buffered or in progress are discarded.

## Timing
- Reset values:
  - `proc_we`, `proc_mode`, `proc_f`, `proc_ra1`, `proc_ra2`, `proc_dst`, `proc_data`, `busy`, `issued_cnt` = 0.
  - `cmd_ready` = 0 while `rst_n`=0 and 1 on the first cycle after reset.
- Latency, with an empty FIFO and no pause:
  - Command pushed on edge E0.
  - Loaded on E1; `proc_*` valid and `proc_we`=1 during the cycle after E1.
  - Register-file write on E2.
- Throughput: one operation per cycle. Repeats and successive commands issue back-to-back with no bubble.
- A repeat sees the result of the previous issue, because the register file has written it by the next edge (e.g. dst==ra1 accumulates).
- Pause: `proc_we` falls on the first edge after pause rises, and resumes on the first edge after pause falls.

## Structure
- Package `proc_seq_pkg`:
  - `proc_cmd_t` packed struct (mode, f, ra1, ra2, dst, data, rep);
  - `seq_state_e` enum {IDLE, ISSUE, HOLD};
  - constants `ADDR_W`=5, `DATA_W`=32, `F_W`=3.
- Sub-module `seq_cmd_fifo`: a synchronous FIFO of `proc_cmd_t` with a count output, `DEPTH` entries.
- Top level holds the issue register, `rep_left`, the FSM and `issued_cnt`.

## Test plan
- **Reset:** `rst_n`=0 for 2 cycles with `cmd_valid`=1 → `cmd_ready`=0, `proc_we`=0, `issued_cnt`=0, and no command is buffered after reset.
- **Single store:** push mode=1, dst=5, data=0xDEADBEEF, rep=0 at E0 → `proc_we`=1 for exactly one cycle after E1 with `proc_mode`=1, `proc_dst`=5, `proc_data`=0xDEADBEEF; `issued_cnt`=1; `busy` low afterwards.
- **Repeat:** ALU command f=3'b010, ra1=1, ra2=2, dst=1, rep=3 → `proc_we` high for 4 consecutive cycles with fields constant; `issued_cnt`=4.
- **Full FIFO:** pause=1, push 4 commands → `cmd_ready`=0 after the 4th, and the 5th stays held. Release pause → 4 ops issue back-to-back in push order, then the 5th is accepted and issued.
- **Pause mid-repeat:** rep=5; assert pause after 2 issues for 3 cycles → `proc_we`=0 for those 3 cycles, then 4 more issues; total `issued_cnt`=6.
- **Reset mid-operation:** during a repeat with 2 commands buffered, pull `rst_n` low for 1 edge → all outputs are 0 after that edge and nothing further issues.
